xswitch_egress_arbiter: RTL

//   Round-robin packet arbiter for one egress port of the 4x4 xswitch. Up to NUM_REQ

---
 rtl/xswitch_egress_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/xswitch_egress_arbiter.sv
// xswitch_egress_arbiter: round-robin packet arbiter muxing one ingress port onto an egress stream
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   req        per-port packet request
//   req_len    per-port packet length (beats-1), port i at [i*LEN_W +: LEN_W]
//   req_data   per-port data beat, port i at [i*DATA_W +: DATA_W]
//   req_valid  per-port beat valid
//   req_ready  per-port beat accept (only the granted port can see 1)
//   grant      one-hot registered grant, zero when idle
//   out_data   egress beat
//   out_valid  egress beat valid
//   out_ready  egress backpressure
//   busy       high while a packet is in flight
//   pkt_done   one-cycle pulse in the idle cycle after a packet's last beat
module xswitch_egress_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      pkt_done
);
    localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic IDLE = 1'b0;
    localparam logic XFER = 1'b1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic             state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] g_idx;
    logic [LEN_W-1:0] cnt;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             xfer;
    int               j;

    // Scan from the farthest offset down to rr_ptr+1 so the nearest requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[j]) begin
                found  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end

    assign busy      = (state == XFER);
    assign out_valid = busy && req_valid[g_idx];
    assign out_data  = busy ? req_data[g_idx*DATA_W +: DATA_W] : '0;
    assign req_ready = (busy && out_ready) ? grant : '0;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            g_idx    <= '0;
            cnt      <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    state  <= XFER;
                    grant  <= ONE << winner;
                    g_idx  <= winner;
                    rr_ptr <= winner;
                    cnt    <= req_len[winner*LEN_W +: LEN_W];
                end
            end else if (xfer) begin
                if (cnt == '0) begin
                    state    <= IDLE;
                    grant    <= '0;
                    pkt_done <= 1'b1;
                end else begin
                    cnt <= cnt - LEN_W'(1);
                end
            end
        end
    end
endmodule
